// File: rtl/cc_io_bridge.sv
// cc_io_bridge: port-bus peripheral for the PicoBlaze command/control core.
//   - register file decoded from port_id[3:0] (capture control, IRQ status/mask,
//     trigger mask/value words)
//   - TX/RX byte FIFOs between the core and the UART
//   - registered read mux onto port_in (1-cycle latency, no strobe gating)
//   - sticky maskable interrupt with a REQ/ack/service handshake
// Optional feature: define CC_IO_LOOPBACK_EN to drain the TX FIFO straight into
// the RX FIFO (tx_valid held 0, rx_valid/rx_data/tx_ready ignored).
// Ports: clk, reset_n (async, active low); port_id/port_out/port_in with
// write_strobe/kwrite_strobe/read_strobe; interrupt/interrupt_ack;
// cap_arm/cap_abort/cap_status/cap_done; trig_mask/trig_value;
// tx_data/tx_valid/tx_ready; rx_data/rx_valid.

// Byte FIFO. A push is accepted when not full, or when full with a pop in
// the same cycle (count stays unchanged). Callers only pop when non-empty.
module cc_io_bridge_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       last,
    output logic       push_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign last    = (count == (AW+1)'(1));
    assign push_ok = push && (!full || pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        end
    end
endmodule

module cc_io_bridge #(
    parameter int CH_WIDTH      = 16,
    parameter int TX_FIFO_DEPTH = 16,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          port_id,
    input  logic [7:0]          port_out,
    output logic [7:0]          port_in,
    input  logic                write_strobe,
    input  logic                kwrite_strobe,
    input  logic                read_strobe,
    output logic                interrupt,
    input  logic                interrupt_ack,
    output logic                cap_arm,
    output logic                cap_abort,
    input  logic [7:0]          cap_status,
    input  logic                cap_done,
    output logic [CH_WIDTH-1:0] trig_mask,
    output logic [CH_WIDTH-1:0] trig_value,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid
);
    localparam int NB = CH_WIDTH / 8;

    typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_SVC} irq_state_t;

    logic [3:0] addr;
    logic       wr, flush;
    logic [4:0] status, status_set, status_clr;
    logic [7:0] mask;
    logic [7:0] rd_mux;
    irq_state_t irq_state;

    logic       tx_push, tx_pop, tx_empty, tx_full, tx_last, tx_push_ok;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_empty, rx_full, rx_last, rx_push_ok;
    logic [7:0] rx_din, rx_head;
    logic       unused;

    assign addr    = port_id[3:0];
    assign wr      = write_strobe | kwrite_strobe;
    assign flush   = wr && addr == 4'h0 && port_out[7];
    assign tx_push = wr && addr == 4'h3;
    assign rx_pop  = read_strobe && addr == 4'h4 && !rx_empty;
    assign tx_data = tx_head;

`ifdef CC_IO_LOOPBACK_EN
    // TX head moves straight into RX whenever RX has room.
    assign tx_pop   = !tx_empty && !rx_full;
    assign rx_push  = tx_pop;
    assign rx_din   = tx_head;
    assign tx_valid = 1'b0;
    assign unused   = &{1'b0, port_id[7:4], rx_last, rx_valid, rx_data, tx_ready};
`else
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign rx_push  = rx_valid;
    assign rx_din   = rx_data;
    assign unused   = &{1'b0, port_id[7:4], rx_last};
`endif

    cc_io_bridge_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .push(tx_push), .pop(tx_pop), .din(port_out), .dout(tx_head),
        .empty(tx_empty), .full(tx_full), .last(tx_last), .push_ok(tx_push_ok)
    );

    cc_io_bridge_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .push(rx_push), .pop(rx_pop), .din(rx_din), .dout(rx_head),
        .empty(rx_empty), .full(rx_full), .last(rx_last), .push_ok(rx_push_ok)
    );

    // Event sources; "drained" means the last byte left with nothing arriving.
    assign status_set = {tx_push && !tx_push_ok,
                         rx_push && !rx_push_ok,
                         tx_pop && !tx_push_ok && tx_last,
                         rx_push_ok,
                         cap_done};
    assign status_clr = (wr && addr == 4'h1) ? port_out[4:0] : 5'b0;

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            4'h0: rd_mux = cap_status;
            4'h1: rd_mux = {3'b000, status};
            4'h2: rd_mux = mask;
            4'h4: rd_mux = rx_head;
            4'h5: rd_mux = {4'b0000, tx_full, tx_empty, rx_full, rx_empty};
            default: begin
                if (addr[3]) begin
                    for (int i = 0; i < NB; i++) begin
                        if (addr[1:0] == 2'(i))
                            rd_mux = addr[2] ? trig_value[i*8 +: 8] : trig_mask[i*8 +: 8];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_in    <= 8'h00;
            cap_arm    <= 1'b0;
            cap_abort  <= 1'b0;
            status     <= 5'b0;
            mask       <= 8'h00;
            trig_mask  <= '0;
            trig_value <= '0;
        end else begin
            port_in   <= rd_mux;
            cap_arm   <= wr && addr == 4'h0 && port_out[0];
            cap_abort <= wr && addr == 4'h0 && port_out[1];
            // set wins over a same-cycle write-1-to-clear
            status    <= (status & ~status_clr) | status_set;
            if (wr && addr == 4'h2) mask <= port_out;
            for (int i = 0; i < NB; i++) begin
                if (wr && addr[3] && addr[1:0] == 2'(i)) begin
                    if (addr[2]) trig_value[i*8 +: 8] <= port_out;
                    else         trig_mask[i*8 +: 8]  <= port_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_state <= IRQ_IDLE;
            interrupt <= 1'b0;
        end else begin
            case (irq_state)
                IRQ_IDLE: if (|(status & mask[4:0])) begin
                    irq_state <= IRQ_REQ;
                    interrupt <= 1'b1;
                end
                IRQ_REQ: if (interrupt_ack) begin
                    irq_state <= IRQ_SVC;
                    interrupt <= 1'b0;
                end
                IRQ_SVC: if (!(|(status & mask[4:0]))) irq_state <= IRQ_IDLE;
                default: begin
                    irq_state <= IRQ_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end
endmodule
